// File: rtl/cache_victim_selector.sv
// Victim-way selector for a set-associative array.
// Prefers a free (invalid, unlocked) way; otherwise walks the round-robin
// pointer downward, skipping locked ways, and requests a pointer advance.
// The result is registered behind a valid/ready handshake with one cycle of latency.
module cache_victim_selector #(
  parameter int N_WAYS = 2,
  localparam int WAY_IDX_LEN = $clog2(N_WAYS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [N_WAYS-1:0]      valid_ways_i,
  input  logic [N_WAYS-1:0]      dirty_ways_i,
  input  logic [N_WAYS-1:0]      lock_ways_i,
  input  logic [N_WAYS-1:0]      rr_ptr_i,
  output logic                   rr_update_o,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [N_WAYS-1:0]      victim_oh_o,
  output logic [WAY_IDX_LEN-1:0] victim_idx_o,
  output logic                   victim_evict_o,
  output logic                   victim_dirty_o,
  output logic                   alloc_fail_o
);

  logic [N_WAYS-1:0]      w_free;
  logic [N_WAYS-1:0]      w_unlocked;
  logic [N_WAYS-1:0]      w_victim_oh;
  logic [WAY_IDX_LEN-1:0] w_victim_idx;
  logic                   w_has_free;
  logic                   w_any_unlocked;
  logic                   w_replace;
  logic                   w_fail;
  logic                   w_dirty;
  logic                   w_accept;

  logic                   r_resp_valid;
  logic                   r_rr_update;
  logic [N_WAYS-1:0]      r_victim_oh;
  logic [WAY_IDX_LEN-1:0] r_victim_idx;
  logic                   r_evict;
  logic                   r_dirty;
  logic                   r_fail;

  assign w_accept    = req_valid_i && req_ready_o;
  assign req_ready_o = !r_resp_valid || resp_ready_i;

  // Pick the victim: lowest free way, else first unlocked way walking p, p-1, ..., wrapping.
  always_comb begin : sel
    int unsigned v_ptr;
    int unsigned v_free_idx;
    int unsigned v_rr_idx;
    int unsigned v_way;
    int unsigned v_sel;
    w_free         = ~valid_ways_i & ~lock_ways_i;
    w_unlocked     = ~lock_ways_i;
    w_has_free     = |w_free;
    w_any_unlocked = |w_unlocked;
    w_replace      = !w_has_free && w_any_unlocked;
    w_fail         = !w_any_unlocked;
    // Malformed pointer: multi-hot takes the lowest bit, all-zero means top way.
    v_ptr = N_WAYS - 1;
    for (int unsigned i = N_WAYS; i > 0; i--) begin
      if (rr_ptr_i[i-1]) v_ptr = i - 1;
    end
    v_free_idx = 0;
    for (int unsigned i = N_WAYS; i > 0; i--) begin
      if (w_free[i-1]) v_free_idx = i - 1;
    end
    // Walked backwards so the last hit (step 0 = pointer way) is the earliest in search order.
    v_rr_idx = 0;
    v_way    = 0;
    for (int unsigned k = N_WAYS; k > 0; k--) begin
      v_way = (v_ptr >= k - 1) ? (v_ptr - (k - 1)) : (v_ptr + N_WAYS - (k - 1));
      if (w_unlocked[v_way]) v_rr_idx = v_way;
    end
    v_sel        = w_has_free ? v_free_idx : v_rr_idx;
    w_victim_oh  = '0;
    w_victim_idx = '0;
    if (!w_fail) begin
      w_victim_oh[v_sel] = 1'b1;
      w_victim_idx       = WAY_IDX_LEN'(v_sel);
    end
    w_dirty = w_replace && dirty_ways_i[v_sel];
  end

  // Response registers, valid flag and pointer-advance pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_rr_update  <= 1'b0;
      r_victim_oh  <= '0;
      r_victim_idx <= '0;
      r_evict      <= 1'b0;
      r_dirty      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_rr_update <= w_accept && w_replace;
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_victim_oh  <= w_victim_oh;
        r_victim_idx <= w_victim_idx;
        r_evict      <= w_replace;
        r_dirty      <= w_dirty;
        r_fail       <= w_fail;
      end else if (resp_ready_i) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid_o   = r_resp_valid;
  assign rr_update_o    = r_rr_update;
  assign victim_oh_o    = r_victim_oh;
  assign victim_idx_o   = r_victim_idx;
  assign victim_evict_o = r_evict;
  assign victim_dirty_o = r_dirty;
  assign alloc_fail_o   = r_fail;

endmodule

// File: tb/tb_cache_victim_selector.sv
// Directed bench for cache_victim_selector with N_WAYS = 4.
module tb_cache_victim_selector;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] valid_ways;
  logic [3:0] dirty_ways;
  logic [3:0] lock_ways;
  logic [3:0] rr_ptr;
  logic       rr_update;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] victim_oh;
  logic [1:0] victim_idx;
  logic       victim_evict;
  logic       victim_dirty;
  logic       alloc_fail;

  int vectors;
  int miscompares;
  int pulse_cnt;

  // {resp_valid, victim_oh[3:0], victim_idx[1:0], evict, dirty, fail}
  logic [9:0] resp;
  assign resp = {resp_valid, victim_oh, victim_idx, victim_evict, victim_dirty, alloc_fail};

  cache_victim_selector #(.N_WAYS(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .valid_ways_i  (valid_ways),
    .dirty_ways_i  (dirty_ways),
    .lock_ways_i   (lock_ways),
    .rr_ptr_i      (rr_ptr),
    .rr_update_o   (rr_update),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .victim_oh_o   (victim_oh),
    .victim_idx_o  (victim_idx),
    .victim_evict_o(victim_evict),
    .victim_dirty_o(victim_dirty),
    .alloc_fail_o  (alloc_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count update pulses on the falling edge, mid-cycle.
  initial pulse_cnt = 0;
  always @(negedge clk) if (rr_update === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic set_req(input logic [3:0] v, input logic [3:0] d,
                         input logic [3:0] l, input logic [3:0] p);
    valid_ways = v;
    dirty_ways = d;
    lock_ways  = l;
    rr_ptr     = p;
    req_valid  = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (resp !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_resp: got %b want %b", resp, 10'b0);
    end
    vectors++;
    if (rr_update !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rr_update: got %b want 0", rr_update);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    step();
  endtask

  task automatic test_free_way;
    int p0;
    p0 = pulse_cnt;
    set_req(4'b1011, 4'b0000, 4'b0000, 4'b1000);
    step();
    req_valid = 1'b0;
    vectors++;
    if (resp !== 10'b1010010000) begin
      miscompares++;
      $display("FAIL free_resp: got %b want %b", resp, 10'b1010010000);
    end
    step();
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL free_consumed: resp_valid got %b want 0", resp_valid);
    end
    vectors++;
    if (pulse_cnt - p0 !== 0) begin
      miscompares++;
      $display("FAIL free_pulses: got %0d want 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_rr_replace;
    int p0;
    p0 = pulse_cnt;
    set_req(4'b1111, 4'b0100, 4'b0000, 4'b0100);
    step();
    req_valid = 1'b0;
    vectors++;
    if (resp !== 10'b1010010110) begin
      miscompares++;
      $display("FAIL rr1_resp: got %b want %b", resp, 10'b1010010110);
    end
    vectors++;
    if (rr_update !== 1'b1) begin
      miscompares++;
      $display("FAIL rr1_update_high: got %b want 1", rr_update);
    end
    step();
    vectors++;
    if (rr_update !== 1'b0) begin
      miscompares++;
      $display("FAIL rr1_update_low: got %b want 0", rr_update);
    end
    // Pointer register has rotated 0100 -> 0010.
    set_req(4'b1111, 4'b0100, 4'b0000, 4'b0010);
    step();
    req_valid = 1'b0;
    vectors++;
    if (resp !== 10'b1001001100) begin
      miscompares++;
      $display("FAIL rr2_resp: got %b want %b", resp, 10'b1001001100);
    end
    step();
    vectors++;
    if (pulse_cnt - p0 !== 2) begin
      miscompares++;
      $display("FAIL rr_pulses: got %0d want 2", pulse_cnt - p0);
    end
  endtask

  task automatic test_lock_wrap;
    int p0;
    p0 = pulse_cnt;
    set_req(4'b1111, 4'b0000, 4'b0011, 4'b0001);
    step();
    req_valid = 1'b0;
    vectors++;
    if (resp !== 10'b1100011100) begin
      miscompares++;
      $display("FAIL wrap_resp: got %b want %b", resp, 10'b1100011100);
    end
    step();
    vectors++;
    if (pulse_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL wrap_pulses: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_all_locked;
    int p0;
    p0 = pulse_cnt;
    set_req(4'b1111, 4'b1111, 4'b1111, 4'b0100);
    step();
    req_valid = 1'b0;
    vectors++;
    if (resp !== 10'b1000000001) begin
      miscompares++;
      $display("FAIL locked_resp: got %b want %b", resp, 10'b1000000001);
    end
    step();
    vectors++;
    if (pulse_cnt - p0 !== 0) begin
      miscompares++;
      $display("FAIL locked_pulses: got %0d want 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_malformed_ptr;
    logic [3:0] tv[3];
    logic [3:0] td[3];
    logic [3:0] tl[3];
    logic [3:0] tp[3];
    logic [9:0] te[3];
    // zero pointer -> way 3 (locked) -> way 2
    tv[0] = 4'b1111; td[0] = 4'b0100; tl[0] = 4'b1000; tp[0] = 4'b0000; te[0] = 10'b1010010110;
    // multi-hot pointer -> lowest bit, way 1
    tv[1] = 4'b1111; td[1] = 4'b0010; tl[1] = 4'b0000; tp[1] = 4'b0110; te[1] = 10'b1001001110;
    // locked invalid way is not free; next free is way 1
    tv[2] = 4'b0000; td[2] = 4'b1111; tl[2] = 4'b0001; tp[2] = 4'b0001; te[2] = 10'b1001001000;
    for (int i = 0; i < 3; i++) begin
      set_req(tv[i], td[i], tl[i], tp[i]);
      step();
      req_valid = 1'b0;
      vectors++;
      if (resp !== te[i]) begin
        miscompares++;
        $display("FAIL malformed_%0d: got %b want %b", i, resp, te[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulse_cnt;
    set_req(4'b1111, 4'b0000, 4'b0000, 4'b1000);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (resp !== 10'b1100011100 || rr_update !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_%0d: got resp %b upd %b want %b upd 1", i, resp, rr_update, 10'b1100011100);
      end
    end
    req_valid = 1'b0;
    step();
    vectors++;
    if (rr_update !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got upd %b valid %b want 0 0", rr_update, resp_valid);
    end
    vectors++;
    if (pulse_cnt - p0 !== 2) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - p0);
    end
  endtask

  task automatic test_backpressure;
    int p0;
    p0 = pulse_cnt;
    resp_ready = 1'b0;
    set_req(4'b1111, 4'b1000, 4'b0000, 4'b1000);
    step();
    set_req(4'b1110, 4'b0000, 4'b0000, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (req_ready !== 1'b0 || resp !== 10'b1100011110) begin
        miscompares++;
        $display("FAIL stall_%0d: got ready %b resp %b want ready 0 resp %b", i, req_ready, resp, 10'b1100011110);
      end
      step();
    end
    resp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (resp !== 10'b1000100000) begin
      miscompares++;
      $display("FAIL release_resp: got %b want %b", resp, 10'b1000100000);
    end
    step();
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release_drain: resp_valid got %b want 0", resp_valid);
    end
    vectors++;
    if (pulse_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL stall_pulses: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    resp_ready = 1'b0;
    set_req(4'b1011, 4'b0000, 4'b0000, 4'b1000);
    step();
    set_req(4'b1111, 4'b1111, 4'b0000, 4'b1000);
    step();
    vectors++;
    if (resp !== 10'b1010010000) begin
      miscompares++;
      $display("FAIL mid_held: got %b want %b", resp, 10'b1010010000);
    end
    p0 = pulse_cnt;
    rst = 1'b1;
    resp_ready = 1'b1;
    step();
    vectors++;
    if (resp !== 10'b0 || rr_update !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got resp %b upd %b ready %b want 0 0 1", resp, rr_update, req_ready);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    step();
    vectors++;
    if (pulse_cnt - p0 !== 0 || rr_update !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_pulses: got %0d upd %b want 0 0", pulse_cnt - p0, rr_update);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    resp_ready  = 1'b1;
    valid_ways  = '0;
    dirty_ways  = '0;
    lock_ways   = '0;
    rr_ptr      = '0;
    test_reset();
    test_free_way();
    test_rr_replace();
    test_lock_wrap();
    test_all_locked();
    test_malformed_ptr();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_victim_selector.md
Name: cache_victim_selector

Overview:
- Consumer of the one-hot round-robin pointer that `one_hot_shift_reg` produces. Per allocation request it picks the way of a set-associative array (cache/TLB) to be filled.
- Selection order: an invalid, unlocked way first; otherwise the round-robin way, skipping locked ways.
- Pulses `rr_update_o` to advance the pointer register whenever a valid way is replaced.
- Request/response valid-ready handshake with registered, one-cycle-latency result.

Parameters:
- `N_WAYS`, 2: number of ways; equals `REG_LEN` of the pointer register; must be >= 2.
- `WAY_IDX_LEN`, `$clog2(N_WAYS)`: width of the encoded way index (derived, not overridden).

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  allocation request.
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`.
- `valid_ways_i`  in  N_WAYS  per-way valid bits of the addressed set; sampled on accept.
- `dirty_ways_i`  in  N_WAYS  per-way dirty bits; sampled on accept.
- `lock_ways_i`  in  N_WAYS  per-way lock bits (1 = must not be selected); sampled on accept.
- `rr_ptr_i`  in  N_WAYS  one-hot round-robin pointer from the pointer register.
- `rr_update_o`  out  1  one-cycle pulse: advance the pointer register.
- `resp_valid_o`  out  1  result available.
- `resp_ready_i`  in  1  result consumed when `resp_valid_o && resp_ready_i`.
- `victim_oh_o`  out  N_WAYS  selected way, one-hot; 0 on failure.
- `victim_idx_o`  out  WAY_IDX_LEN  selected way, binary; 0 on failure.
- `victim_evict_o`  out  1  selected way held valid data (replacement, not free fill).
- `victim_dirty_o`  out  1  selected way was valid and dirty (write-back needed).
- `alloc_fail_o`  out  1  every way locked; no way selected.

Behaviour:
- **Reset:** while `rst_i` = 1 at a clock edge:
  - `resp_valid_o`, `victim_oh_o`, `victim_idx_o`, `victim_evict_o`, `victim_dirty_o`, `alloc_fail_o` and `rr_update_o` all go to 0.
  - A pending response is discarded; no update pulse is issued.
  - `req_ready_o` = 1 in the first cycle after reset.
- **Handshake:**
  - `req_ready_o = !resp_valid_o || resp_ready_i` (combinational).
  - Accept at edge T: response registers load and `resp_valid_o` = 1 from T+1.
  - Response fields are held stable while `resp_valid_o && !resp_ready_i`.
  - On response consumed without a new accept, `resp_valid_o` -> 0.
  - Consume and accept in the same cycle: the new result replaces the old one (one result per cycle sustained).
- **Selection** (combinational on the inputs at accept), with `free = ~valid_ways_i & ~lock_ways_i`:
  1. `free != 0`: victim = lowest-index set bit of `free`; `victim_evict_o` = 0, `victim_dirty_o` = 0, no pointer update.
  2. `free == 0` and `~lock_ways_i != 0`: search order starts at the pointer way p and goes p, p-1, ..., 0, N_WAYS-1, ..., p+1, matching the pointer rotation direction (bit k moves to k-1, bit 0 wraps to N_WAYS-1).
     - Victim = first unlocked way in that order.
     - `victim_evict_o` = 1; `victim_dirty_o` = `dirty_ways_i[victim]`.
  3. All ways locked: `alloc_fail_o` = 1, `victim_oh_o` = 0, `victim_idx_o` = 0, evict/dirty = 0, no update.
- **Pointer update:**
  - `rr_update_o` is registered: it is 1 for exactly the cycle T+1 after an accept that took case 2, else 0.
  - The pointer register samples it at edge T+1 and shows the new value from T+2.
  - A back-to-back accept at edge T+1 may therefore still see the old pointer. That is legal: the pointer register advances once per pulse, and the next selection uses whatever `rr_ptr_i` shows at its own accept.
  - Only one pulse per replacement, even when locked ways were skipped.
- **Malformed pointer:**
  - `rr_ptr_i` multi-hot: p = lowest set bit.
  - `rr_ptr_i` all-zero: p = N_WAYS-1.
  - Neither case is an error condition.
- **Invariants:**
  - `victim_oh_o` is zero or one-hot; `victim_idx_o` always encodes it.
  - `victim_dirty_o` implies `victim_evict_o`.
  - `alloc_fail_o` excludes both evict and dirty.
- **Area:** no storage beyond the response registers, `resp_valid_o` and the `rr_update_o` flop.

Test Plan:
- **Reset and free way:** N_WAYS=4; apply reset, then req with valid=4'b1011, lock=0, ptr=4'b1000 -> next cycle resp_valid=1, victim_oh=4'b0100, idx=2, evict=0, rr_update_o never 1.
- **Round-robin replacement:** valid=4'b1111, dirty=4'b0100, lock=0, ptr=4'b0100 -> victim_oh=4'b0100, idx=2, evict=1, dirty=1, rr_update_o=1 for one cycle. With a `one_hot_shift_reg` attached, the next identical req yields victim 4'b0010, dirty=0.
- **Locked skip and wrap:** valid=4'b1111, lock=4'b0011, ptr=4'b0001 -> search 0 (locked), 3 -> victim_oh=4'b1000, idx=3, one update pulse.
- **All locked:** lock=4'b1111 -> alloc_fail=1, victim_oh=0, idx=0, evict=0, no rr_update_o.
- **Backpressure and throughput:**
  - Hold resp_ready_i=0 for 3 cycles after a response; req_valid_i high -> req_ready_o=0, outputs stable, no extra pulses.
  - Then resp_ready_i=1 -> new request accepted in the same cycle; next response appears the following cycle.
- **Reset mid-operation:** assert rst_i while resp_valid_o=1 and unconsumed -> next cycle all outputs 0, req_ready_o=1, no rr_update_o pulse.
